// File: rtl/pipe_stage_chain.sv
// Chain of STAGES enable-gated pipeline registers with valid/ready handshake, bubble collapsing,
// synchronous flush and a registered occupancy count. Define PIPE_STAGE_CHAIN_DATA_RESET_EN to reset data too.
module pipe_stage_chain #(
    parameter int               WIDTH       = 32,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] load;
    logic              in_xfer;
    logic              out_xfer;

    // A stage can take a word whenever some stage between it and the consumer has room to move
    always_comb begin
        logic acc;
        acc   = out_ready;
        ready = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc      = acc | ~valid_q[k];
            ready[k] = acc;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] src;

        if (k == 0) begin : g_head
            assign up_valid[k] = in_valid;
            assign src         = in_data;
        end else begin : g_body
            assign up_valid[k] = valid_q[k-1];
            assign src         = g_stage[k-1].data_q;
        end

        assign load[k] = ready[k] & up_valid[k] & ~flush;

`ifdef PIPE_STAGE_CHAIN_DATA_RESET_EN
        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= RESET_VALUE;
            end else if (load[k]) begin
                data_q <= src;
            end
        end
`else
        always_ff @(posedge clk) begin
            if (load[k]) begin
                data_q <= src;
            end
        end
`endif
    end

`ifndef PIPE_STAGE_CHAIN_DATA_RESET_EN
    // RESET_VALUE only matters when the data registers are reset
    logic [WIDTH-1:0] unused_reset_value;
    assign unused_reset_value = RESET_VALUE;
`endif

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= 1'b1;
                end else if (ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = ready[0] & ~flush;
    assign out_valid = valid_q[STAGES-1] & ~flush;
    assign out_data  = g_stage[STAGES-1].data_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: a 3-stage and a 1-stage instance checked against a
// queue-based model where each word becomes visible STAGES cycles after acceptance or one after its predecessor leaves.
module tb_pipe_stage_chain;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic        a_reset = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;

    logic        b_reset = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [0:0]  b_occ;

    pipe_stage_chain #(.WIDTH(32), .STAGES(3), .RESET_VALUE(32'hDEADBEEF)) dut (
        .clk(clk), .reset(a_reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_chain #(.WIDTH(32), .STAGES(1), .RESET_VALUE(32'h5A5A5A5A)) dut1 (
        .clk(clk), .reset(b_reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    // Reference model: queue of words with the cycle each was accepted
    logic [31:0] a_qd[$];
    int          a_qa[$];
    int          a_last = -100;
    int          a_cyc  = 0;
    logic [31:0] b_qd[$];
    int          b_qa[$];
    int          b_last = -100;
    int          b_cyc  = 0;

    function automatic bit m_in_ready(int sz, int s, logic fl, logic ordy);
        return !fl && (sz < s || ordy);
    endfunction

    function automatic bit m_out_valid(int sz, int head_acc, int last, int cyc, int s, logic fl);
        int avail;
        if (fl || sz == 0) return 1'b0;
        avail = (head_acc + s > last + 1) ? head_acc + s : last + 1;
        return avail <= cyc;
    endfunction

    function automatic bit a_exp_ready();
        return m_in_ready(a_qd.size(), 3, a_flush, a_out_ready);
    endfunction
    function automatic bit a_exp_valid();
        return m_out_valid(a_qd.size(), (a_qa.size() > 0) ? a_qa[0] : 0, a_last, a_cyc, 3, a_flush);
    endfunction
    function automatic bit b_exp_ready();
        return m_in_ready(b_qd.size(), 1, b_flush, b_out_ready);
    endfunction
    function automatic bit b_exp_valid();
        return m_out_valid(b_qd.size(), (b_qa.size() > 0) ? b_qa[0] : 0, b_last, b_cyc, 1, b_flush);
    endfunction

    task automatic a_step();
        bit acc_in, take_out;
        acc_in   = a_in_valid && a_exp_ready();
        take_out = a_exp_valid() && a_out_ready;
        @(posedge clk);
        if (a_reset || a_flush) begin
            a_qd.delete(); a_qa.delete();
        end else begin
            if (take_out) begin void'(a_qd.pop_front()); void'(a_qa.pop_front()); a_last = a_cyc; end
            if (acc_in) begin a_qd.push_back(a_in_data); a_qa.push_back(a_cyc); end
        end
        a_cyc++;
        #1;
    endtask

    task automatic b_step();
        bit acc_in, take_out;
        acc_in   = b_in_valid && b_exp_ready();
        take_out = b_exp_valid() && b_out_ready;
        @(posedge clk);
        if (b_reset || b_flush) begin
            b_qd.delete(); b_qa.delete();
        end else begin
            if (take_out) begin void'(b_qd.pop_front()); void'(b_qa.pop_front()); b_last = b_cyc; end
            if (acc_in) begin b_qd.push_back(b_in_data); b_qa.push_back(b_cyc); end
        end
        b_cyc++;
        #1;
    endtask

    task automatic a_clear();
        a_flush = 1'b1; a_in_valid = 1'b0;
        a_step();
        a_flush = 1'b0;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1;
        a_step(); a_step();
        b_qd.delete(); b_qa.delete();
        a_reset = 1'b0; b_reset = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b exp=0", a_out_valid); else passed++;
        checks++; if (a_occ !== 2'd0) $display("[TB] FAIL reset_occupancy got=%0d exp=0", a_occ); else passed++;
        checks++; if (a_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got=%b exp=1", a_in_ready); else passed++;
        checks++; if (b_out_valid !== 1'b0) $display("[TB] FAIL reset_s1_out_valid got=%b exp=0", b_out_valid); else passed++;
        checks++; if (b_in_ready !== 1'b1) $display("[TB] FAIL reset_s1_in_ready got=%b exp=1", b_in_ready); else passed++;
`ifdef PIPE_STAGE_CHAIN_DATA_RESET_EN
        checks++; if (a_out_data !== 32'hDEADBEEF) $display("[TB] FAIL reset_out_data got=%h exp=deadbeef", a_out_data); else passed++;
        checks++; if (b_out_data !== 32'h5A5A5A5A) $display("[TB] FAIL reset_s1_out_data got=%h exp=5a5a5a5a", b_out_data); else passed++;
`endif
    endtask

    task automatic test_streaming();
        a_clear();
        a_out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            a_in_valid = (i < 16);
            a_in_data  = 32'(i + 1);
            #1;
            checks++; if (a_in_ready !== a_exp_ready()) $display("[TB] FAIL stream_in_ready i=%0d got=%b exp=%b", i, a_in_ready, a_exp_ready()); else passed++;
            checks++; if (a_out_valid !== a_exp_valid()) $display("[TB] FAIL stream_out_valid i=%0d got=%b exp=%b", i, a_out_valid, a_exp_valid()); else passed++;
            checks++; if (a_occ !== 2'(a_qd.size())) $display("[TB] FAIL stream_occupancy i=%0d got=%0d exp=%0d", i, a_occ, a_qd.size()); else passed++;
            if (i >= 3 && i < 19) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== 32'(i - 2))
                    $display("[TB] FAIL stream_latency i=%0d got=%b/%h exp=1/%h", i, a_out_valid, a_out_data, 32'(i - 2));
                else passed++;
            end
            if (i >= 3 && i < 16) begin
                checks++; if (a_occ !== 2'd3) $display("[TB] FAIL stream_occ_steady i=%0d got=%0d exp=3", i, a_occ); else passed++;
            end
            a_step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [4];
        logic [31:0] got[$];
        int          sent;
        words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC; words[3] = 32'hD;
        sent = 0;
        a_clear();
        a_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) a_out_ready = 1'b1;
            a_in_valid = (sent < 4);
            a_in_data  = (sent < 4) ? words[sent] : 32'h0;
            #1;
            checks++; if (a_in_ready !== a_exp_ready()) $display("[TB] FAIL backp_in_ready i=%0d got=%b exp=%b", i, a_in_ready, a_exp_ready()); else passed++;
            checks++; if (a_out_valid !== a_exp_valid()) $display("[TB] FAIL backp_out_valid i=%0d got=%b exp=%b", i, a_out_valid, a_exp_valid()); else passed++;
            if (a_exp_valid()) begin
                checks++; if (a_out_data !== a_qd[0]) $display("[TB] FAIL backp_out_data i=%0d got=%h exp=%h", i, a_out_data, a_qd[0]); else passed++;
            end
            if (i == 6) begin
                checks++; if (a_in_ready !== 1'b0 || a_occ !== 2'd3) $display("[TB] FAIL backp_full got=%b/%0d exp=0/3", a_in_ready, a_occ); else passed++;
            end
            if (a_out_valid && a_out_ready) got.push_back(a_out_data);
            if (a_in_valid && a_exp_ready()) sent++;
            a_step();
        end
        checks++;
        if (got.size() != 4) $display("[TB] FAIL backp_drain_count got=%0d exp=4", got.size());
        else if (got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC || got[3] !== 32'hD)
            $display("[TB] FAIL backp_drain_order got=%h,%h,%h,%h exp=a,b,c,d", got[0], got[1], got[2], got[3]);
        else passed++;
    endtask

    task automatic test_bubble_collapse();
        a_clear();
        a_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = (i == 0 || i == 3);
            a_in_data  = (i == 0) ? 32'h11 : 32'h22;
            #1;
            checks++; if (a_in_ready !== a_exp_ready()) $display("[TB] FAIL bubble_in_ready i=%0d got=%b exp=%b", i, a_in_ready, a_exp_ready()); else passed++;
            checks++; if (a_occ !== 2'(a_qd.size())) $display("[TB] FAIL bubble_occupancy i=%0d got=%0d exp=%0d", i, a_occ, a_qd.size()); else passed++;
            a_step();
        end
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_occ !== 2'd2) $display("[TB] FAIL bubble_occ got=%0d exp=2", a_occ); else passed++;
        checks++; if (dut.valid_q !== 3'b110) $display("[TB] FAIL bubble_stages got=%b exp=110", dut.valid_q); else passed++;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (a_out_valid !== a_exp_valid()) $display("[TB] FAIL bubble_out_valid i=%0d got=%b exp=%b", i, a_out_valid, a_exp_valid()); else passed++;
            if (a_exp_valid()) begin
                checks++; if (a_out_data !== a_qd[0]) $display("[TB] FAIL bubble_out_data i=%0d got=%h exp=%h", i, a_out_data, a_qd[0]); else passed++;
            end
            a_step();
        end
    endtask

    task automatic test_flush();
        a_clear();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = (i < 3);
            a_in_data  = 32'h31 + 32'(i);
            a_step();
        end
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h99; a_out_ready = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) $display("[TB] FAIL flush_out_valid got=%b exp=0", a_out_valid); else passed++;
        checks++; if (a_in_ready !== 1'b0) $display("[TB] FAIL flush_in_ready got=%b exp=0", a_in_ready); else passed++;
        checks++; if (a_occ !== 2'd3) $display("[TB] FAIL flush_occ_before got=%0d exp=3", a_occ); else passed++;
        a_step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        #1;
        checks++; if (a_occ !== 2'd0) $display("[TB] FAIL flush_occ_after got=%0d exp=0", a_occ); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("[TB] FAIL flush_out_valid_after got=%b exp=0", a_out_valid); else passed++;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = (i == 0);
            a_in_data  = 32'h44;
            #1;
            checks++;
            if (a_out_valid !== (i == 3) || (i == 3 && a_out_data !== 32'h44))
                $display("[TB] FAIL flush_restart i=%0d got=%b/%h exp=%b/44", i, a_out_valid, a_out_data, (i == 3));
            else passed++;
            a_step();
        end
    endtask

    task automatic test_reset_midstream();
        a_clear();
        a_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h70 + 32'(i);
            a_step();
        end
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_occ !== 2'd2) $display("[TB] FAIL rstmid_occ_before got=%0d exp=2", a_occ); else passed++;
        a_reset = 1'b1;
        a_step();
        a_reset = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) $display("[TB] FAIL rstmid_out_valid got=%b exp=0", a_out_valid); else passed++;
        checks++; if (a_occ !== 2'd0) $display("[TB] FAIL rstmid_occ got=%0d exp=0", a_occ); else passed++;
        checks++; if (a_in_ready !== 1'b1) $display("[TB] FAIL rstmid_in_ready got=%b exp=1", a_in_ready); else passed++;
`ifdef PIPE_STAGE_CHAIN_DATA_RESET_EN
        checks++; if (a_out_data !== 32'hDEADBEEF) $display("[TB] FAIL rstmid_out_data got=%h exp=deadbeef", a_out_data); else passed++;
`endif
    endtask

    task automatic test_random_s3();
        for (int i = 0; i < 400; i++) begin
            a_flush     = ($urandom_range(0, 39) == 0);
            a_in_valid  = $urandom_range(0, 1);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_in_data   = $urandom;
            #1;
            checks++; if (a_in_ready !== a_exp_ready()) $display("[TB] FAIL rand3_in_ready i=%0d got=%b exp=%b", i, a_in_ready, a_exp_ready()); else passed++;
            checks++; if (a_out_valid !== a_exp_valid()) $display("[TB] FAIL rand3_out_valid i=%0d got=%b exp=%b", i, a_out_valid, a_exp_valid()); else passed++;
            checks++; if (a_occ !== 2'(a_qd.size())) $display("[TB] FAIL rand3_occupancy i=%0d got=%0d exp=%0d", i, a_occ, a_qd.size()); else passed++;
            if (a_exp_valid()) begin
                checks++; if (a_out_data !== a_qd[0]) $display("[TB] FAIL rand3_out_data i=%0d got=%h exp=%h", i, a_out_data, a_qd[0]); else passed++;
            end
            a_step();
        end
        a_flush = 1'b0;
    endtask

    task automatic test_stages1_random();
        b_reset = 1'b1;
        b_step();
        b_reset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            b_in_valid  = $urandom_range(0, 1);
            b_out_ready = $urandom_range(0, 1);
            b_in_data   = $urandom;
            #1;
            checks++; if (b_in_ready !== b_exp_ready()) $display("[TB] FAIL s1_in_ready i=%0d got=%b exp=%b", i, b_in_ready, b_exp_ready()); else passed++;
            checks++; if (b_out_valid !== b_exp_valid()) $display("[TB] FAIL s1_out_valid i=%0d got=%b exp=%b", i, b_out_valid, b_exp_valid()); else passed++;
            checks++; if (b_occ !== 1'(b_qd.size())) $display("[TB] FAIL s1_occupancy i=%0d got=%0d exp=%0d", i, b_occ, b_qd.size()); else passed++;
            if (b_exp_valid()) begin
                checks++; if (b_out_data !== b_qd[0]) $display("[TB] FAIL s1_out_data i=%0d got=%h exp=%h", i, b_out_data, b_qd[0]); else passed++;
            end
            b_step();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_reset_midstream();
        test_random_s3();
        test_stages1_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised chain of enable-gated pipeline registers with a valid/ready handshake, per-stage bubble collapsing, synchronous flush and an occupancy count. It replaces hand-instantiated enable flops between processor stages: a producer stage (e.g. fetch/decode) pushes words in, and a consumer stage pulls them out. Stalls and flushes (branch mispredict, trap) are handled in one place.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- STAGES, 2, number of register stages (1..8)
- RESET_VALUE, 0, WIDTH-bit value loaded into data registers on reset (see Configuration)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous discard of all held words
- in_valid  in  1  producer offers in_data
- in_ready  out  1  chain accepts in_data this cycle
- in_data  in  WIDTH  producer word
- out_valid  out  1  last stage holds a word
- out_ready  in  1  consumer takes out_data this cycle
- out_data  out  WIDTH  last-stage word
- occupancy  out  $clog2(STAGES+1)  number of valid stages

## Operation
- Each stage k (0 = input side, STAGES-1 = output side) holds valid_k and data_k.
- Stage advance: adv_k = valid_k & ready_{k+1}.
- Stage readiness: ready_k = ~valid_k | adv_k, with ready_STAGES = out_ready. Ready ripples combinationally from out_ready to in_ready; there is no skid register.
- in_ready = ready_0 & ~flush. out_valid = valid_{STAGES-1} & ~flush. out_data = data_{STAGES-1}.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Stage k loads data_{k-1}, or in_data for stage 0, when ready_k is high and the upstream word is valid. In that case valid_k <= 1.
- If stage k advances and receives nothing, valid_k <= 0.
- A stage whose ready_k is low holds data_k unchanged. This is the enable-flop behaviour.
- Bubbles collapse: an empty stage accepts upstream data even while downstream is stalled.
- Flush:
  - All valid_k <= 0 on the next edge.
  - No input is accepted and no output is presented in the flush cycle, regardless of in_valid/out_ready.
  - Data registers are unchanged.
- occupancy = popcount of valid_k. Maintain it as a registered counter: +1 on input transfer, −1 on output transfer, unchanged when both occur. Set to 0 on flush or reset.
- Reset has priority over flush. Flush has priority over transfers.

## Timing
- Reset values: all valid_k = 0, out_valid = 0, occupancy = 0, in_ready = 1 (when flush = 0). out_data depends on Configuration.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N+STAGES−1, i.e. available for transfer in cycle N+STAGES when out_ready is held high.
- Throughput: one word per cycle with no stall. Full chain with out_ready = 1: accepting and emitting in the same cycle is legal.
- Full: occupancy == STAGES and out_ready = 0 → in_ready = 0. The chain holds all words indefinitely, with no loss or duplication.
- Empty: out_valid = 0. out_ready is ignored.
- Reset or flush mid-stream: in-flight words are dropped. The first word accepted in the cycle after deassertion appears STAGES cycles later.
- STAGES = 1: degenerates to a single enable register, with in_ready = ~valid_0 | out_ready.

## Configuration
- PIPE_STAGE_CHAIN_DATA_RESET_EN:
  - Defined: reset also loads every data_k with RESET_VALUE, so out_data = RESET_VALUE after reset.
  - Undefined: only valid bits and occupancy reset. Data registers have no reset (less area and reset fan-out), and out_data is undefined until the first word reaches the last stage.
- Handshake behaviour is identical in both builds.

## Test plan
- Streaming, STAGES=3, WIDTH=32, out_ready=1: push 0x1..0x10 back-to-back → each word appears 3 cycles after its acceptance, in order, one per cycle; occupancy steady at 3.
- Backpressure: out_ready=0 while pushing 0xA,0xB,0xC,0xD → the first three are accepted and in_ready drops after 0xC. Raising out_ready → 0xA,0xB,0xC,0xD drain in order, with no duplicates or losses.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22 with out_ready=0 → occupancy reaches 2, and the words occupy stages 2 and 1 (adjacent, no gap).
- Flush with 3 words held, asserted for one cycle alongside in_valid=1 (data 0x99) → out_valid=0 and in_ready=0 in the flush cycle; next cycle occupancy=0 and 0x99 was not accepted.
- Reset mid-stream with occupancy=2 → next cycle out_valid=0, occupancy=0. With PIPE_STAGE_CHAIN_DATA_RESET_EN and RESET_VALUE=0xDEADBEEF, out_data=0xDEADBEEF.
- STAGES=1, random in_valid/out_ready for 1000 cycles → the scoreboard matches the in-order sequence, and occupancy never exceeds 1.
